// File: rtl/gen_mode_arbiter_pkg.sv
// Shared types and helpers for the mode-selectable arbiter.
// Holds the policy/state enums and the one-hot to binary index decoder.
package arb_pkg;

  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = 4;

  typedef enum logic [1:0] {
    ARB_FIXED   = 2'd0,
    ARB_RR      = 2'd1,
    ARB_RR_WDOG = 2'd2
  } arb_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_e;

  // Width of a binary index over n requesters; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // OR-reduction decode; only meaningful for one-hot or all-zero inputs.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | MAX_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/gen_mode_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The master side drives requests and done; the slave side (arbiter) drives grants.
interface gen_mode_arbiter_if
  import arb_pkg::*;
#(
  parameter int N_REQ = 3
);
  localparam int IDX_W = idx_width(N_REQ);

  logic [N_REQ-1:0] i_req;
  logic             i_done;
  logic [N_REQ-1:0] o_gnt;
  logic [IDX_W-1:0] o_gnt_idx;
  logic             o_busy;
  logic             o_timeout;

  modport master (
    output i_req, i_done,
    input  o_gnt, o_gnt_idx, o_busy, o_timeout
  );

  modport slave (
    input  i_req, i_done,
    output o_gnt, o_gnt_idx, o_busy, o_timeout
  );

endinterface

// File: rtl/gen_mode_arbiter_rr_pick.sv
// Combinational rotating picker: first masked request at or above ptr, wrapping.
// With ptr tied to zero it degenerates to a lowest-index priority encoder.
module rr_pick #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_REQ-1:0] mask,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N_REQ-1:0]   cand;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  assign cand = req & mask;

  // Rotate the candidates so ptr lands at bit 0, find the first hit, then undo the rotation.
  // NOTE: every signal written here gets a default first, so no path leaves it
  // holding its old value and no latch is inferred.
  always_comb begin
    found = 1'b0;
    off   = '0;
    dbl   = {cand, cand} >> ptr;
    rot   = dbl[N_REQ-1:0];
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = IDX_W'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
    idx = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/gen_mode_arbiter.sv
// Single-owner arbiter with elaboration-time policy: fixed priority, round-robin,
// or round-robin with a hold watchdog. Ownership persists until done, drop or expiry.
module gen_mode_arbiter
  import arb_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int MODE     = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  gen_mode_arbiter_if.slave  bus
);

  localparam int IDX_W = idx_width(N_REQ);

  arb_state_e       state, state_n;
  logic [N_REQ-1:0] gnt, gnt_n;
  logic [N_REQ-1:0] req, mask;
  logic [IDX_W-1:0] ptr_eff, win;
  logic             found, grant, release_c, expire, owner_req, timeout_q;

  assign req       = bus.i_req;
  assign owner_req = |(req & gnt);
  // A timed-out owner sits out the re-arbitration that evicts it.
  assign mask      = expire ? ~gnt : '1;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_eff),
    .mask  (mask),
    .found (found),
    .idx   (win)
  );

  if (MODE == int'(ARB_FIXED)) begin : g_fixed
    assign ptr_eff = '0;
    assign expire  = 1'b0;
  end else if (MODE == int'(ARB_RR) || MODE == int'(ARB_RR_WDOG)) begin : g_rr
    logic [IDX_W-1:0] ptr;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ptr <= '0;
      end else if (grant) begin
        ptr <= (win == IDX_W'(N_REQ-1)) ? '0 : win + IDX_W'(1);
      end
    end
    assign ptr_eff = ptr;

    if (MODE == int'(ARB_RR_WDOG) && MAX_HOLD > 0) begin : g_wdog
      localparam int CNT_W = $clog2(MAX_HOLD + 1);
      logic [CNT_W-1:0] cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (grant) begin
          cnt <= '0;
        end else if (state == OWNED && cnt != '1) begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      // Done or a dropped request releases anyway, so expiry only fires on its own.
      assign expire = (state == OWNED) && (cnt == CNT_W'(MAX_HOLD-1)) &&
                      !bus.i_done && owner_req;
    end else begin : g_no_wdog
      assign expire = 1'b0;
    end
  end else begin : g_bad_mode
    $error("gen_mode_arbiter: illegal MODE %0d", MODE);
    assign ptr_eff = '0;
    assign expire  = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      timeout_q <= expire;
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt;
    grant     = 1'b0;
    release_c = 1'b0;
    case (state)
      IDLE: begin
        grant = found;
      end
      OWNED: begin
        release_c = bus.i_done || !owner_req || expire;
        if (release_c) begin
          grant = found;
          if (!found) begin
            state_n = IDLE;
            gnt_n   = '0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
      end
    endcase
    if (grant) begin
      state_n = OWNED;
      gnt_n   = {{(N_REQ-1){1'b0}}, 1'b1} << win;
    end
  end

  assign bus.o_gnt     = gnt;
  assign bus.o_busy    = (state == OWNED);
  assign bus.o_timeout = timeout_q;
  assign bus.o_gnt_idx = IDX_W'(onehot_to_idx(MAX_REQ'(gnt)));

endmodule

// File: tb/tb_gen_mode_arbiter.sv
// Drives fixed-priority, round-robin and watchdog instances side by side and compares
// each against a cycle-level reference model of the ownership rules.
module tb_gen_mode_arbiter;
  import arb_pkg::*;

  localparam int N    = 3;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gen_mode_arbiter_if #(.N_REQ(N)) if_fp ();
  gen_mode_arbiter_if #(.N_REQ(N)) if_rr ();
  gen_mode_arbiter_if #(.N_REQ(N)) if_wd ();

  gen_mode_arbiter #(.N_REQ(N), .MODE(0), .MAX_HOLD(HOLD)) u_fp (.clk(clk), .rst(rst), .bus(if_fp));
  gen_mode_arbiter #(.N_REQ(N), .MODE(1), .MAX_HOLD(HOLD)) u_rr (.clk(clk), .rst(rst), .bus(if_rr));
  gen_mode_arbiter #(.N_REQ(N), .MODE(2), .MAX_HOLD(HOLD)) u_wd (.clk(clk), .rst(rst), .bus(if_wd));

  int errors = 0;
  int checks = 0;

  // Reference state per instance: 0 = fixed, 1 = round-robin, 2 = round-robin + watchdog.
  int         m_mode [3] = '{0, 1, 2};
  int         m_owner[3];
  int         m_ptr  [3];
  int         m_held [3];
  bit         m_to   [3];
  logic [N-1:0] req_v [3];
  bit           done_v[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int mode, input logic [N-1:0] c, input int ptr);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (mode == 0) ? k : (ptr + k) % N;
      if (((c >> j) & 3'b001) != 3'b000) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_owner[d] = -1;
      m_ptr[d]   = 0;
      m_held[d]  = 0;
      m_to[d]    = 1'b0;
    end
  endtask

  task automatic model_step(input int d);
    int           w;
    logic [N-1:0] c;
    bit           dropped, exp;
    w        = -1;
    m_to[d]  = 1'b0;
    if (m_owner[d] < 0) begin
      w = pick(m_mode[d], req_v[d], m_ptr[d]);
    end else begin
      m_held[d]++;
      dropped = ((req_v[d] >> m_owner[d]) & 3'b001) == 3'b000;
      exp     = (m_mode[d] == 2) && (m_held[d] >= HOLD) && !done_v[d] && !dropped;
      if (done_v[d] || dropped || exp) begin
        c = req_v[d];
        if (exp) c = c & ~(3'b001 << m_owner[d]);
        w = pick(m_mode[d], c, m_ptr[d]);
        if (w < 0) m_owner[d] = -1;
        m_to[d] = exp;
      end
    end
    if (w >= 0) begin
      m_owner[d] = w;
      m_ptr[d]   = (w + 1) % N;
      m_held[d]  = 0;
    end
  endtask

  task automatic drive();
    if_fp.i_req = req_v[0]; if_fp.i_done = done_v[0];
    if_rr.i_req = req_v[1]; if_rr.i_done = done_v[1];
    if_wd.i_req = req_v[2]; if_wd.i_done = done_v[2];
  endtask

  task automatic check_all();
    logic [N-1:0] g[3];
    logic [1:0]   ix[3];
    logic         b[3], t[3];
    logic [N-1:0] eg;
    g[0] = if_fp.o_gnt; ix[0] = if_fp.o_gnt_idx; b[0] = if_fp.o_busy; t[0] = if_fp.o_timeout;
    g[1] = if_rr.o_gnt; ix[1] = if_rr.o_gnt_idx; b[1] = if_rr.o_busy; t[1] = if_rr.o_timeout;
    g[2] = if_wd.o_gnt; ix[2] = if_wd.o_gnt_idx; b[2] = if_wd.o_busy; t[2] = if_wd.o_timeout;
    for (int d = 0; d < 3; d++) begin
      eg = (m_owner[d] >= 0) ? (3'b001 << m_owner[d]) : 3'b000;
      check($sformatf("gnt[m%0d]", d), 32'(g[d]), 32'(eg));
      check($sformatf("busy[m%0d]", d), 32'(b[d]), 32'(m_owner[d] >= 0));
      check($sformatf("timeout[m%0d]", d), 32'(t[d]), 32'(m_to[d]));
      if (m_owner[d] >= 0) check($sformatf("idx[m%0d]", d), 32'(ix[d]), 32'(m_owner[d]));
    end
  endtask

  task automatic tick();
    drive();
    for (int d = 0; d < 3; d++) model_step(d);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asserts reset between edges so the drop is visible without a clock.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  int exp_rot[7] = '{0, 1, 1, 2, 2, 0, 0};

  initial begin
    for (int d = 0; d < 3; d++) begin
      req_v[d]  = '0;
      done_v[d] = 1'b0;
    end
    drive();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // First grant, then reset while owned, then a fresh request pattern.
    req_v[1] = 3'b001;
    tick();
    tick();
    do_reset();
    check("rst_mid_gnt", 32'(if_rr.o_gnt), 32'h0);
    req_v[1] = 3'b110;
    tick();
    check("rr_first_gnt", 32'(if_rr.o_gnt), 32'h2);
    check("rr_first_idx", 32'(if_rr.o_gnt_idx), 32'h1);

    // Rotation with done every second cycle.
    req_v[1] = '0;
    do_reset();
    req_v[1] = 3'b111;
    for (int i = 1; i <= 7; i++) begin
      done_v[1] = (i % 2 == 0);
      tick();
      check($sformatf("rr_rot_idx%0d", i), 32'(if_rr.o_gnt_idx), 32'(exp_rot[i-1]));
      check($sformatf("rr_rot_busy%0d", i), 32'(if_rr.o_busy), 32'h1);
    end
    done_v[1] = 1'b0;

    // Fixed priority: index 0 wins every time.
    req_v[0]  = 3'b111;
    done_v[0] = 1'b1;
    repeat (6) begin
      tick();
      check("fp_starve", 32'(if_fp.o_gnt), 32'h1);
    end
    done_v[0] = 1'b0;

    // Owner drops its request without done.
    req_v[0] = 3'b100;
    tick();
    check("drop_owner2", 32'(if_fp.o_gnt_idx), 32'h2);
    req_v[0] = 3'b001;
    tick();
    check("drop_regrant", 32'(if_fp.o_gnt), 32'h1);

    // Sole requester with done every cycle keeps being regranted.
    req_v[1]  = 3'b001;
    done_v[1] = 1'b1;
    repeat (5) begin
      tick();
      check("sole_busy", 32'(if_rr.o_busy), 32'h1);
      check("sole_gnt", 32'(if_rr.o_gnt), 32'h1);
    end
    done_v[1] = 1'b0;

    // Watchdog expiry after HOLD owned cycles.
    req_v[0] = '0;
    req_v[1] = '0;
    do_reset();
    req_v[2] = 3'b011;
    repeat (4) tick();
    check("wd_pre_gnt", 32'(if_wd.o_gnt), 32'h1);
    check("wd_pre_to", 32'(if_wd.o_timeout), 32'h0);
    tick();
    check("wd_exp_gnt", 32'(if_wd.o_gnt), 32'h2);
    check("wd_exp_to", 32'(if_wd.o_timeout), 32'h1);
    tick();
    check("wd_to_pulse", 32'(if_wd.o_timeout), 32'h0);

    // Done coinciding with expiry suppresses the timeout.
    do_reset();
    repeat (4) tick();
    done_v[2] = 1'b1;
    tick();
    check("wd_done_to", 32'(if_wd.o_timeout), 32'h0);
    check("wd_done_gnt", 32'(if_wd.o_gnt), 32'h2);
    done_v[2] = 1'b0;

    // Random traffic with sticky requests so long holds occur.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      for (int d = 0; d < 3; d++) begin
        if ($urandom_range(0, 3) == 0) req_v[d] = 3'($urandom_range(0, 7));
        done_v[d] = ($urandom_range(0, 4) == 0);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
